dma_twod_midend: RTL and testbench

Two-dimensional transfer midend of the DMA. It accepts one `twod_req_t` descriptor per handshake and unrolls it into `num_repetitions` 1D `burst_req_t` requests with strided source and destination addresses. These requests feed the burst reshaper/backend. The block also tracks backend completions in order and emits one completion pulse per finished 2D (or pass-through 1D) job.

---
 rtl/dma_twod_midend.sv | 229 ++++++++++++++++++++++
 tb/tb_dma_twod_midend.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_twod_midend.sv
// Two-dimensional DMA midend: unrolls one 2D descriptor into a sequence of
// strided 1D bursts and reports in-order completion of each whole job.

package axi_dma_pkg;
  typedef logic [63:0] addr_t;
  typedef logic [3:0]  id_t;

  typedef struct packed {
    id_t        id;
    addr_t      src;
    addr_t      dst;
    addr_t      num_bytes;
    logic [3:0] cache_src;
    logic [3:0] cache_dst;
    logic [1:0] burst_src;
    logic [1:0] burst_dst;
    logic       decouple_rw;
    logic       deburst;
  } burst_req_t;

  typedef struct packed {
    id_t        id;
    logic       is_twod;
    addr_t      src;
    addr_t      dst;
    addr_t      num_bytes;
    addr_t      stride_src;
    addr_t      stride_dst;
    addr_t      num_repetitions;
    logic [3:0] cache_src;
    logic [3:0] cache_dst;
    logic [1:0] burst_src;
    logic [1:0] burst_dst;
    logic       decouple_rw;
    logic       deburst;
  } twod_req_t;
endpackage

module dma_twod_midend #(
  parameter int unsigned DoneFifoDepth = 8,
  parameter type twod_req_t  = axi_dma_pkg::twod_req_t,
  parameter type burst_req_t = axi_dma_pkg::burst_req_t,
  parameter type addr_t      = axi_dma_pkg::addr_t,
  parameter type id_t        = axi_dma_pkg::id_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  twod_req_t  twod_req_i,
  input  logic       twod_req_valid_i,
  output logic       twod_req_ready_o,
  output burst_req_t burst_req_o,
  output logic       burst_req_valid_o,
  input  logic       burst_req_ready_i,
  input  logic       burst_done_i,
  output logic       twod_done_o,
  output id_t        twod_done_id_o,
  output logic       busy_o
);

  localparam int unsigned PtrW = (DoneFifoDepth > 1) ? $clog2(DoneFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(DoneFifoDepth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t FifoFull = cnt_t'(DoneFifoDepth);
  localparam ptr_t PtrLast  = ptr_t'(DoneFifoDepth - 1);

  typedef enum logic {IDLE, UNROLL} state_t;

  // Circular pointer advance for a depth that need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrLast) ? '0 : p + ptr_t'(1);
  endfunction

  state_t     state_q, state_d;
  // burst_q is the outgoing burst itself; its src/dst fields are the running addresses.
  burst_req_t burst_q, burst_d;
  addr_t      stride_src_q, stride_src_d;
  addr_t      stride_dst_q, stride_dst_d;
  addr_t      reps_left_q, reps_left_d;

  id_t        id_mem_q [DoneFifoDepth];
  id_t        id_mem_d [DoneFifoDepth];
  logic       last_mem_q [DoneFifoDepth];
  logic       last_mem_d [DoneFifoDepth];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       count_q, count_d;
  logic       twod_done_q, twod_done_d;
  id_t        twod_done_id_q, twod_done_id_d;

  logic       fifo_full, fifo_empty;
  logic       push, push_last, pop;

  // Full/empty come straight from the registered count, so a pop frees a slot only next cycle.
  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);
  assign pop        = burst_done_i & ~fifo_empty;

  // Unroll FSM: descriptor capture, burst issue and address stepping.
  always_comb begin
    state_d           = state_q;
    burst_d           = burst_q;
    stride_src_d      = stride_src_q;
    stride_dst_d      = stride_dst_q;
    reps_left_d       = reps_left_q;
    twod_req_ready_o  = 1'b0;
    burst_req_valid_o = 1'b0;
    push              = 1'b0;
    push_last         = 1'b0;
    unique case (state_q)
      IDLE: begin
        twod_req_ready_o = 1'b1;
        if (twod_req_valid_i) begin
          burst_d.id          = twod_req_i.id;
          burst_d.src         = twod_req_i.src;
          burst_d.dst         = twod_req_i.dst;
          burst_d.num_bytes   = twod_req_i.num_bytes;
          burst_d.cache_src   = twod_req_i.cache_src;
          burst_d.cache_dst   = twod_req_i.cache_dst;
          burst_d.burst_src   = twod_req_i.burst_src;
          burst_d.burst_dst   = twod_req_i.burst_dst;
          burst_d.decouple_rw = twod_req_i.decouple_rw;
          burst_d.deburst     = twod_req_i.deburst;
          stride_src_d        = twod_req_i.stride_src;
          stride_dst_d        = twod_req_i.stride_dst;
          // A 1D job, or a 2D job with zero repetitions, still moves one burst.
          if (!twod_req_i.is_twod || (twod_req_i.num_repetitions == '0)) begin
            reps_left_d = addr_t'(1);
          end else begin
            reps_left_d = twod_req_i.num_repetitions;
          end
          state_d = UNROLL;
        end
      end
      UNROLL: begin
        burst_req_valid_o = ~fifo_full;
        if (~fifo_full && burst_req_ready_i) begin
          burst_d.src = burst_q.src + stride_src_q;
          burst_d.dst = burst_q.dst + stride_dst_q;
          reps_left_d = reps_left_q - addr_t'(1);
          push        = 1'b1;
          push_last   = (reps_left_q == addr_t'(1));
          if (reps_left_q == addr_t'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign burst_req_o = burst_q;

  // Done FIFO bookkeeping and completion pulse generation.
  always_comb begin
    id_mem_d       = id_mem_q;
    last_mem_d     = last_mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    twod_done_d    = 1'b0;
    twod_done_id_d = twod_done_id_q;
    if (push) begin
      id_mem_d[wr_ptr_q]   = burst_q.id;
      last_mem_d[wr_ptr_q] = push_last;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      if (last_mem_q[rd_ptr_q]) begin
        twod_done_d    = 1'b1;
        twod_done_id_d = id_mem_q[rd_ptr_q];
      end
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  assign twod_done_o    = twod_done_q;
  assign twod_done_id_o = twod_done_id_q;
  assign busy_o         = (state_q == UNROLL) | ~fifo_empty;

  // State and datapath registers; reset flushes the FIFO and clears the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      burst_q        <= '0;
      stride_src_q   <= '0;
      stride_dst_q   <= '0;
      reps_left_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      twod_done_q    <= 1'b0;
      twod_done_id_q <= '0;
    end else begin
      state_q        <= state_d;
      burst_q        <= burst_d;
      stride_src_q   <= stride_src_d;
      stride_dst_q   <= stride_dst_d;
      reps_left_q    <= reps_left_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      twod_done_q    <= twod_done_d;
      twod_done_id_q <= twod_done_id_d;
    end
  end

  // FIFO storage needs no reset: entries are only read below the registered count.
  always_ff @(posedge clk_i) begin
    id_mem_q   <= id_mem_d;
    last_mem_q <= last_mem_d;
  end

  // A completion with nothing outstanding is a backend protocol error; it is dropped.
  always @(posedge clk_i) begin
    if (!rst_i && burst_done_i) begin
      assert (!fifo_empty)
        else $warning("dma_twod_midend: burst_done_i with no outstanding burst, ignored");
    end
  end

endmodule

// File: tb/tb_dma_twod_midend.sv
// Directed bench for dma_twod_midend: 1D pass-through, 2D unroll, backpressure,
// address wrap, zero repetitions, done-FIFO full stall and reset mid-job.
module tb_dma_twod_midend;
  import axi_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default FIFO depth.
  twod_req_t  req_a;
  logic       rv_a, rr_a, bv_a, bready_a, bd_a, td_a, busy_a;
  burst_req_t br_a;
  id_t        tdid_a;

  // Instance B: two-entry FIFO for the full-stall case.
  twod_req_t  req_b;
  logic       rv_b, rr_b, bv_b, bready_b, bd_b, td_b, busy_b;
  burst_req_t br_b;
  id_t        tdid_b;

  int n_tests = 0;
  int n_fail  = 0;

  dma_twod_midend dut_a (
    .clk_i(clk), .rst_i(rst),
    .twod_req_i(req_a), .twod_req_valid_i(rv_a), .twod_req_ready_o(rr_a),
    .burst_req_o(br_a), .burst_req_valid_o(bv_a), .burst_req_ready_i(bready_a),
    .burst_done_i(bd_a), .twod_done_o(td_a), .twod_done_id_o(tdid_a), .busy_o(busy_a)
  );

  dma_twod_midend #(.DoneFifoDepth(2)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .twod_req_i(req_b), .twod_req_valid_i(rv_b), .twod_req_ready_o(rr_b),
    .burst_req_o(br_b), .burst_req_valid_o(bv_b), .burst_req_ready_i(bready_b),
    .burst_done_i(bd_b), .twod_done_o(td_b), .twod_done_id_o(tdid_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic twod_req_t mk(input logic [3:0] id, input logic is2d,
                                   input logic [63:0] src, input logic [63:0] ssrc,
                                   input logic [63:0] dst, input logic [63:0] sdst,
                                   input logic [63:0] nb,  input logic [63:0] reps);
    twod_req_t r;
    r = '0;
    r.id = id; r.is_twod = is2d; r.src = src; r.stride_src = ssrc;
    r.dst = dst; r.stride_dst = sdst; r.num_bytes = nb; r.num_repetitions = reps;
    r.cache_src = 4'h3; r.cache_dst = 4'h5; r.burst_src = 2'b01; r.burst_dst = 2'b01;
    return r;
  endfunction

  task automatic accept_a(input twod_req_t r);
    req_a = r; rv_a = 1'b1;
    check("accept_a_ready", {63'd0, rr_a}, 64'd1);
    step();
    rv_a = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"}, {63'd0, rr_a}, 64'd1);
    check({tag, "_bvalid"}, {63'd0, bv_a}, 64'd0);
    check({tag, "_breq_zero"}, {63'd0, (br_a == '0)}, 64'd1);
    check({tag, "_done"}, {63'd0, td_a}, 64'd0);
    check({tag, "_done_id"}, {60'd0, tdid_a}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy_a}, 64'd0);
  endtask

  initial begin
    int hs;
    logic [19:0] pat;

    req_a = '0; rv_a = 0; bready_a = 0; bd_a = 0;
    req_b = '0; rv_b = 0; bready_b = 0; bd_b = 0;
    step(); step();
    check_reset_a("rst");
    check("rst_b_bvalid", {63'd0, bv_b}, 64'd0);
    rst = 1'b0;

    // 1D pass-through.
    bready_a = 1'b1;
    accept_a(mk(4'd3, 1'b0, 64'h1000, 64'h0, 64'h2000, 64'h0, 64'd64, 64'd7));
    check("p1_valid", {63'd0, bv_a}, 64'd1);
    check("p1_src", br_a.src, 64'h1000);
    check("p1_dst", br_a.dst, 64'h2000);
    check("p1_nbytes", br_a.num_bytes, 64'd64);
    check("p1_id", {60'd0, br_a.id}, 64'd3);
    step();
    check("p1_single_burst", {63'd0, bv_a}, 64'd0);
    check("p1_ready_back", {63'd0, rr_a}, 64'd1);
    check("p1_busy_outstanding", {63'd0, busy_a}, 64'd1);
    bd_a = 1'b1; step(); bd_a = 1'b0;
    check("p1_done", {63'd0, td_a}, 64'd1);
    check("p1_done_id", {60'd0, tdid_a}, 64'd3);
    step();
    check("p1_done_one_cycle", {63'd0, td_a}, 64'd0);
    check("p1_idle_busy", {63'd0, busy_a}, 64'd0);

    // 2D unroll at full throughput.
    accept_a(mk(4'd9, 1'b1, 64'h1000, 64'h100, 64'h8000, 64'h40, 64'd32, 64'd4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p2_valid%0d", i), {63'd0, bv_a}, 64'd1);
      check($sformatf("p2_src%0d", i), br_a.src, 64'h1000 + 64'(i) * 64'h100);
      check($sformatf("p2_dst%0d", i), br_a.dst, 64'h8000 + 64'(i) * 64'h40);
      step();
    end
    check("p2_end_valid", {63'd0, bv_a}, 64'd0);
    check("p2_end_ready", {63'd0, rr_a}, 64'd1);
    bd_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("p2_done_after%0d", i + 1), {63'd0, td_a}, (i == 3) ? 64'd1 : 64'd0);
    end
    bd_a = 1'b0;
    check("p2_done_id", {60'd0, tdid_a}, 64'd9);
    step();
    check("p2_done_pulse_end", {63'd0, td_a}, 64'd0);
    check("p2_busy_end", {63'd0, busy_a}, 64'd0);

    // Backpressure: fixed irregular ready pattern.
    pat = 20'b1101_0110_0101_1010_0100;
    hs = 0;
    accept_a(mk(4'd4, 1'b1, 64'h4000, 64'h10, 64'h9000, 64'h20, 64'd8, 64'd3));
    for (int i = 0; i < 20; i++) begin
      bready_a = pat[i];
      if (bv_a) begin
        check($sformatf("p3_src_c%0d", i), br_a.src, 64'h4000 + 64'(hs) * 64'h10);
        check($sformatf("p3_dst_c%0d", i), br_a.dst, 64'h9000 + 64'(hs) * 64'h20);
        if (bready_a) hs++;
      end
      step();
    end
    check("p3_handshakes", 64'(hs), 64'd3);
    check("p3_end_valid", {63'd0, bv_a}, 64'd0);
    bready_a = 1'b1;
    bd_a = 1'b1; step(); step(); step(); bd_a = 1'b0;
    check("p3_done", {63'd0, td_a}, 64'd1);
    check("p3_done_id", {60'd0, tdid_a}, 64'd4);
    step();

    // Address wrap-around.
    accept_a(mk(4'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'h100, 64'h0, 64'h0, 64'd0, 64'd2));
    check("p4_src0", br_a.src, 64'hFFFF_FFFF_FFFF_FF00);
    check("p4_nbytes_zero", br_a.num_bytes, 64'd0);
    step();
    check("p4_valid1", {63'd0, bv_a}, 64'd1);
    check("p4_src_wrap", br_a.src, 64'h0);
    step();
    check("p4_end_valid", {63'd0, bv_a}, 64'd0);
    bd_a = 1'b1; step(); step(); bd_a = 1'b0;
    check("p4_done", {63'd0, td_a}, 64'd1);
    step();

    // is_twod with zero repetitions gives exactly one burst.
    accept_a(mk(4'd7, 1'b1, 64'h500, 64'h10, 64'h600, 64'h10, 64'd4, 64'd0));
    check("p4z_valid", {63'd0, bv_a}, 64'd1);
    check("p4z_src", br_a.src, 64'h500);
    step();
    check("p4z_single", {63'd0, bv_a}, 64'd0);
    check("p4z_ready", {63'd0, rr_a}, 64'd1);
    bd_a = 1'b1; step(); bd_a = 1'b0;
    check("p4z_done", {63'd0, td_a}, 64'd1);
    check("p4z_done_id", {60'd0, tdid_a}, 64'd7);
    step();

    // Done FIFO full on the two-entry instance.
    bready_b = 1'b1;
    req_b = mk(4'd2, 1'b1, 64'h100, 64'h8, 64'h200, 64'h8, 64'd16, 64'd3);
    rv_b = 1'b1; step(); rv_b = 1'b0;
    check("p5_valid0", {63'd0, bv_b}, 64'd1);
    step();
    check("p5_valid1", {63'd0, bv_b}, 64'd1);
    check("p5_src1", br_b.src, 64'h108);
    step();
    check("p5_full_stall", {63'd0, bv_b}, 64'd0);
    step();
    check("p5_full_stall_hold", {63'd0, bv_b}, 64'd0);
    check("p5_src_held", br_b.src, 64'h110);
    bd_b = 1'b1; step(); bd_b = 1'b0;
    check("p5_valid_return", {63'd0, bv_b}, 64'd1);
    check("p5_src2", br_b.src, 64'h110);
    check("p5_no_done_yet", {63'd0, td_b}, 64'd0);
    step();
    check("p5_third_issued", {63'd0, bv_b}, 64'd0);
    check("p5_ready_back", {63'd0, rr_b}, 64'd1);
    bd_b = 1'b1; step(); step(); bd_b = 1'b0;
    check("p5_done", {63'd0, td_b}, 64'd1);
    check("p5_done_id", {60'd0, tdid_b}, 64'd2);
    step();
    check("p5_busy_end", {63'd0, busy_b}, 64'd0);

    // Reset in the middle of a four-burst job.
    accept_a(mk(4'd8, 1'b1, 64'h3000, 64'h100, 64'h7000, 64'h100, 64'd16, 64'd4));
    step(); step();
    check("p6_pre_busy", {63'd0, busy_a}, 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check_reset_a("p6_rst");
    bd_a = 1'b1;
    step();
    check("p6_orphan_done0", {63'd0, td_a}, 64'd0);
    step();
    check("p6_orphan_done1", {63'd0, td_a}, 64'd0);
    bd_a = 1'b0;
    accept_a(mk(4'd5, 1'b0, 64'hA000, 64'h0, 64'hB000, 64'h0, 64'd128, 64'd0));
    check("p6_new_src", br_a.src, 64'hA000);
    check("p6_new_dst", br_a.dst, 64'hB000);
    step();
    bd_a = 1'b1; step(); bd_a = 1'b0;
    check("p6_new_done", {63'd0, td_a}, 64'd1);
    check("p6_new_done_id", {60'd0, tdid_a}, 64'd5);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
